// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: one access per instruction over a word-wide
// req/ready data-memory port, with lane placement, load extension and fault reporting.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;
  // Last counter value before abort; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [1:0]         size_q, size_d;
  logic               signed_q, signed_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               fault_q, fault_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               access;
  logic               misaligned;
  logic               timeout_hit;
  logic [3:0]         be_new;
  logic [31:0]        wdata_new;
  logic [31:0]        shifted;
  logic [31:0]        load_ext;

  assign access      = req_valid && (req_size != 2'b00);
  assign misaligned  = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    be_new    = 4'b0000;
    wdata_new = 32'h0;
    case (req_size)
      SZ_BYTE: begin
        be_new    = 4'b0001 << req_addr[1:0];
        wdata_new = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_new    = 4'b0011 << req_addr[1:0];
        wdata_new = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        be_new    = 4'b1111;
        wdata_new = req_wdata;
      end
      default: ;
    endcase
  end

  assign shifted = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_q)
      SZ_BYTE: load_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    size_d    = size_q;
    signed_d  = signed_q;
    lane_d    = lane_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    fault_d   = fault_q;
    rdata_d   = rdata_q;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    fault     = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            fault = 1'b1;
          end else begin
            stall    = 1'b1;
            write_d  = req_write;
            size_d   = req_size;
            signed_d = req_signed;
            lane_d   = req_addr[1:0];
            addr_d   = {req_addr[31:2], 2'b00};
            be_d     = be_new;
            wdata_d  = wdata_new;
            fault_d  = 1'b0;
            cnt_d    = '0;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready) begin
          fault_d = mem_err;
          rdata_d = (write_q || mem_err) ? 32'h0 : load_ext;
          state_d = DONE;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          rdata_d = 32'h0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        fault     = fault_q;
        cnt_d     = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      lane_q   <= 2'b00;
      addr_q   <= 32'h0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      lane_q   <= lane_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mem_we    = write_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and random accesses on a long-timeout instance
// and a TIMEOUT=3 instance, checked against an arithmetic reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rv, rw, rsg, mr, me, sel;
  logic [1:0]  rs;
  logic [31:0] ra, rwd, mrd;

  logic        a_stall, a_rsp_valid, a_fault, a_mem_req, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        b_stall, b_rsp_valid, b_fault, b_mem_req, b_mem_we;
  logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;

  logic        o_stall, o_rsp_valid, o_fault, o_mem_req, o_mem_we;
  logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv & ~sel), .req_write(rw), .req_size(rs), .req_signed(rsg),
    .req_addr(ra), .req_wdata(rwd),
    .stall(a_stall), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .fault(a_fault),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_be(a_mem_be),
    .mem_wdata(a_mem_wdata), .mem_ready(mr & ~sel), .mem_rdata(mrd), .mem_err(me & ~sel)
  );

  mem_access_ctrl #(.TIMEOUT(3), .CNT_W(8)) u_dut_to (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv & sel), .req_write(rw), .req_size(rs), .req_signed(rsg),
    .req_addr(ra), .req_wdata(rwd),
    .stall(b_stall), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .fault(b_fault),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
    .mem_wdata(b_mem_wdata), .mem_ready(mr & sel), .mem_rdata(mrd), .mem_err(me & sel)
  );

  assign o_stall     = sel ? b_stall     : a_stall;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_fault     = sel ? b_fault     : a_fault;
  assign o_mem_req   = sel ? b_mem_req   : a_mem_req;
  assign o_mem_we    = sel ? b_mem_we    : a_mem_we;
  assign o_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign o_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign o_mem_be    = sel ? b_mem_be    : a_mem_be;

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_be(logic [1:0] sz, logic [31:0] ad);
    logic [3:0] be;
    int lo;
    lo = (sz == 2'b11) ? 0 : int'(ad % 4);
    be = '0;
    for (int i = 0; i < 4; i++)
      if (i >= lo && i < lo + nbytes(sz)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(logic [1:0] sz, logic [31:0] wd);
    logic [31:0] w;
    int n;
    n = nbytes(sz);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(logic [1:0] sz, bit sg, logic [31:0] ad, logic [31:0] rd);
    longint v, m;
    v = longint'(rd) / (longint'(1) << (8 * (ad % 4)));
    m = longint'(1) << (8 * nbytes(sz));
    v = v % m;
    if (sg && v >= m / 2) v = v - m;
    return 32'(v);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ready_after = number of WAIT cycles without mem_ready before the ready cycle
  task automatic access(bit w, logic [1:0] sz, bit sg, logic [31:0] ad, logic [31:0] wd,
                        logic [31:0] rd, int ready_after, bit err);
    int n_wait;
    bit to;
    logic [31:0] exp_r;
    n_wait = ready_after + 1;
    to = 1'b0;
    if (sel && n_wait > 3) begin to = 1'b1; n_wait = 3; end
    exp_r = (w || err || to) ? 32'h0 : exp_load(sz, sg, ad, rd);
    rv = 1'b1; rw = w; rs = sz; rsg = sg; ra = ad; rwd = wd; mr = 1'b0; me = 1'b0;
    @(negedge clk);
    chk("accept_stall", o_stall, 1);
    chk("accept_noreq", o_mem_req, 0);
    chk("accept_nofault", o_fault, 0);
    tick();
    for (int k = 0; k < n_wait; k++) begin
      mr  = !to && (k == n_wait - 1);
      me  = mr && err;
      mrd = mr ? rd : $urandom();
      @(negedge clk);
      chk("wait_req", o_mem_req, 1);
      chk("wait_stall", o_stall, 1);
      chk("wait_we", o_mem_we, w);
      chk("wait_addr", o_mem_addr, ad & 32'hFFFF_FFFC);
      chk("wait_be", o_mem_be, exp_be(sz, ad));
      chk("wait_wdata", o_mem_wdata, exp_wdata(sz, wd));
      chk("wait_norsp", o_rsp_valid, 0);
      tick();
    end
    mr = 1'b0; me = 1'b0;
    @(negedge clk);
    chk("done_rsp", o_rsp_valid, 1);
    chk("done_stall", o_stall, 0);
    chk("done_req", o_mem_req, 0);
    chk("done_fault", o_fault, err || to);
    chk("done_rdata", o_rsp_rdata, exp_r);
    tick();
  endtask

  task automatic misalign(logic [1:0] sz, logic [31:0] ad);
    rv = 1'b1; rw = 1'b0; rs = sz; ra = ad; mr = 1'b1;
    @(negedge clk);
    chk("mis_fault", o_fault, 1);
    chk("mis_stall", o_stall, 0);
    chk("mis_req", o_mem_req, 0);
    tick();
    rv = 1'b0; mr = 1'b0;
    @(negedge clk);
    chk("mis_after_fault", o_fault, 0);
    chk("mis_after_req", o_mem_req, 0);
    chk("mis_after_rsp", o_rsp_valid, 0);
    tick();
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] ad;
    rst_n = 1'b0; rv = 1'b0; rw = 1'b0; rs = 2'b00; rsg = 1'b0; ra = '0; rwd = '0;
    mr = 1'b0; me = 1'b0; mrd = '0; sel = 1'b0;
    #12;
    chk("rst_stall", o_stall, 0);
    chk("rst_rsp", o_rsp_valid, 0);
    chk("rst_fault", o_fault, 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_we", o_mem_we, 0);
    chk("rst_be", o_mem_be, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_rdata", o_rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    access(0, 2'b01, 1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0);
    access(0, 2'b10, 0, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 0);
    access(1, 2'b01, 0, 32'h0000_3001, 32'h0000_00AB, 32'h1234_5678, 3, 0);
    misalign(2'b11, 32'h0000_4002);
    misalign(2'b10, 32'h0000_4001);
    access(0, 2'b11, 0, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 1, 1);

    // size None and idle mem_ready must do nothing
    rv = 1'b1; rs = 2'b00; mr = 1'b1;
    @(negedge clk);
    chk("none_stall", o_stall, 0);
    chk("none_fault", o_fault, 0);
    tick();
    rv = 1'b0; mr = 1'b0;
    @(negedge clk);
    chk("none_req", o_mem_req, 0);
    chk("none_rsp", o_rsp_valid, 0);
    tick();

    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(1, 3));
      ad = $urandom();
      if ($urandom_range(0, 7) == 0 && sz != 2'b01) begin
        if (sz == 2'b10) ad[0] = 1'b1; else ad[1:0] = 2'($urandom_range(1, 3));
        misalign(sz, ad);
      end else begin
        if (sz == 2'b10) ad[0] = 1'b0;
        if (sz == 2'b11) ad[1:0] = 2'b00;
        access(1'($urandom()), sz, 1'($urandom()), ad, $urandom(), $urandom(),
               $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
      end
    end

    sel = 1'b1;
    access(0, 2'b11, 0, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 2, 0);
    access(0, 2'b11, 0, 32'h0000_6004, 32'h0, 32'h2468_ACE0, 2, 0);
    access(0, 2'b11, 0, 32'h0000_6008, 32'h0, 32'hFFFF_FFFF, 10, 0);
    access(0, 2'b01, 1, 32'h0000_600B, 32'h0, 32'h7F00_0000, 0, 0);
    for (int i = 0; i < 12; i++) begin
      sz = 2'($urandom_range(1, 3));
      ad = $urandom();
      if (sz == 2'b10) ad[0] = 1'b0;
      if (sz == 2'b11) ad[1:0] = 2'b00;
      access(1'($urandom()), sz, 1'($urandom()), ad, $urandom(), $urandom(),
             $urandom_range(0, 5), ($urandom_range(0, 5) == 0));
    end
    sel = 1'b0;

    // asynchronous reset while in WAIT
    rv = 1'b1; rw = 1'b0; rs = 2'b11; rsg = 1'b0; ra = 32'h0000_5000;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("pre_rst_req", o_mem_req, 1);
    @(posedge clk);
    #2;
    rv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_req", o_mem_req, 0);
    chk("arst_stall", o_stall, 0);
    chk("arst_rdata", o_rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_req", o_mem_req, 0);
    chk("post_rst_rsp", o_rsp_valid, 0);
    tick();
    access(0, 2'b10, 1, 32'h0000_5002, 32'h0, 32'h8001_0000, 0, 0);
    access(1, 2'b10, 0, 32'h0000_5006, 32'h0000_C3A5, 32'h0, 1, 0);
    rv = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
